// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU: opcodes, ALU op encoding, sequencer states.
package cpu_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned ALU_W  = 3;
    localparam int unsigned SEL_W  = 2;

    localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB  = 4'h2;
    localparam logic [OPC_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPC_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPC_W-1:0] OP_XOR  = 4'h5;
    localparam logic [OPC_W-1:0] OP_MOV  = 4'h6;
    localparam logic [OPC_W-1:0] OP_LOAD = 4'h9;
    localparam logic [OPC_W-1:0] OP_JMP  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JZ   = 4'hD;
    localparam logic [OPC_W-1:0] OP_HLT  = 4'hF;

    localparam logic [ALU_W-1:0] ALU_NONE  = 3'b000;
    localparam logic [ALU_W-1:0] ALU_ADD   = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SUB   = 3'b010;
    localparam logic [ALU_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALU_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALU_W-1:0] ALU_XOR   = 3'b101;
    localparam logic [ALU_W-1:0] ALU_PASSB = 3'b110;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_OPERAND = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    // Opcodes that carry a second (operand) byte.
    function automatic logic is_two_byte(input logic [OPC_W-1:0] opcode);
        return (opcode == OP_LOAD) || (opcode == OP_JMP) || (opcode == OP_JZ);
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decode of the instruction register.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] ir,
    output logic              reg_we_raw,
    output logic              wb_sel,
    output logic [ALU_W-1:0]  alu_op,
    output logic              flags_we_raw,
    output logic              is_jmp,
    output logic              is_jz,
    output logic              is_hlt,
    output logic              illegal,
    output logic [SEL_W-1:0]  rd_raw,
    output logic [SEL_W-1:0]  rs_raw
);

    logic [OPC_W-1:0] opcode;

    assign opcode = ir[7:4];
    assign rd_raw = ir[3:2];
    assign rs_raw = ir[1:0];

    always_comb begin
        reg_we_raw   = 1'b0;
        wb_sel       = 1'b0;
        alu_op       = ALU_NONE;
        flags_we_raw = 1'b0;
        is_jmp       = 1'b0;
        is_jz        = 1'b0;
        is_hlt       = 1'b0;
        illegal      = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                reg_we_raw   = 1'b1;
                flags_we_raw = 1'b1;
                alu_op       = opcode[2:0];
            end
            OP_MOV: begin
                reg_we_raw = 1'b1;
                alu_op     = ALU_PASSB;
            end
            OP_LOAD: begin
                reg_we_raw = 1'b1;
                wb_sel     = 1'b1;
            end
            OP_JMP: is_jmp = 1'b1;
            OP_JZ:  is_jz  = 1'b1;
            OP_HLT: is_hlt = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// CPU control unit: PC, instruction/operand fetch FSM and gated execute controls.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stall,
    input  logic       zero_flag,
    output logic [7:0] imem_addr,
    input  logic [7:0] imem_data,
    output logic       reg_we,
    output logic [1:0] rd_sel,
    output logic [1:0] rs_sel,
    output logic [2:0] alu_op,
    output logic       wb_sel,
    output logic       flags_we,
    output logic [7:0] imm,
    output logic       halted,
    output logic       illegal_op
);

    state_t            state;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] imm_q;

    logic              dec_reg_we;
    logic              dec_wb_sel;
    logic [ALU_W-1:0]  dec_alu_op;
    logic              dec_flags_we;
    logic              dec_jmp;
    logic              dec_jz;
    logic              dec_hlt;
    logic              dec_illegal;
    logic [SEL_W-1:0]  dec_rd;
    logic [SEL_W-1:0]  dec_rs;
    logic              in_exec;
    logic              fire;

    instr_decoder u_dec (
        .ir          (ir),
        .reg_we_raw  (dec_reg_we),
        .wb_sel      (dec_wb_sel),
        .alu_op      (dec_alu_op),
        .flags_we_raw(dec_flags_we),
        .is_jmp      (dec_jmp),
        .is_jz       (dec_jz),
        .is_hlt      (dec_hlt),
        .illegal     (dec_illegal),
        .rd_raw      (dec_rd),
        .rs_raw      (dec_rs)
    );

    // Sequencer state, PC and fetched bytes; everything freezes under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
            ir    <= 8'h00;
            imm_q <= 8'h00;
        end else if (!stall) begin
            case (state)
                S_FETCH: begin
                    ir    <= imem_data;
                    pc    <= pc + 8'd1;
                    state <= is_two_byte(imem_data[7:4]) ? S_OPERAND : S_EXECUTE;
                end
                S_OPERAND: begin
                    imm_q <= imem_data;
                    pc    <= pc + 8'd1;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (dec_jmp || (dec_jz && zero_flag)) begin
                        pc <= imm_q;
                    end
                    state <= dec_hlt ? S_HALT : S_FETCH;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

    // Controls are visible only in EXECUTE; write strobes also drop while stalled.
    assign in_exec    = (state == S_EXECUTE);
    assign fire       = in_exec && !stall;

    assign imem_addr  = pc;
    assign imm        = imm_q;
    assign halted     = (state == S_HALT);
    assign reg_we     = fire && dec_reg_we;
    assign flags_we   = fire && dec_flags_we;
    assign illegal_op = fire && dec_illegal;
    assign rd_sel     = in_exec ? dec_rd : 2'b00;
    assign rs_sel     = in_exec ? dec_rs : 2'b00;
    assign alu_op     = in_exec ? dec_alu_op : ALU_NONE;
    assign wb_sel     = in_exec && dec_wb_sel;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with a behavioural instruction ROM.
module tb_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       stall;
    logic       zero_flag;
    logic [7:0] imem_addr;
    logic [7:0] imem_data;
    logic       reg_we;
    logic [1:0] rd_sel;
    logic [1:0] rs_sel;
    logic [2:0] alu_op;
    logic       wb_sel;
    logic       flags_we;
    logic [7:0] imm;
    logic       halted;
    logic       illegal_op;

    logic [7:0] mem [256];
    int         errors;
    int         checks;
    int         pulses;

    fetch_sequencer #(.RESET_PC(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .zero_flag (zero_flag),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .reg_we    (reg_we),
        .rd_sel    (rd_sel),
        .rs_sel    (rs_sel),
        .alu_op    (alu_op),
        .wb_sel    (wb_sel),
        .flags_we  (flags_we),
        .imm       (imm),
        .halted    (halted),
        .illegal_op(illegal_op)
    );

    assign imem_data = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Hold reset across one falling edge, check reset values, release mid-cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk8("rst_addr", imem_addr, 8'h00);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_reg_we", reg_we, 1'b0);
        chk1("rst_illegal", illegal_op, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        stall     = 1'b0;
        zero_flag = 1'b0;

        // Program: LOAD r0,0A ; LOAD r1,0B ; SUB r2,r1 ; HLT
        clear_mem();
        mem[0] = 8'h90; mem[1] = 8'h0A; mem[2] = 8'h94; mem[3] = 8'h0B;
        mem[4] = 8'h29; mem[5] = 8'hF0;
        do_reset();
        chk8("rst_imm", imm, 8'h00);
        for (int c = 0; c < 12; c++) begin
            chk1("prog_reg_we", reg_we, (c == 2) || (c == 5) || (c == 7));
            chk1("prog_halted", halted, c >= 10);
            if (c >= 9) chk8("prog_addr_hold", imem_addr, 8'h06);
            if (c == 2) begin
                chk8("c2_rd", 8'(rd_sel), 8'h00);
                chk1("c2_wb", wb_sel, 1'b1);
                chk8("c2_imm", imm, 8'h0A);
                chk1("c2_flags", flags_we, 1'b0);
            end
            if (c == 5) begin
                chk8("c5_rd", 8'(rd_sel), 8'h01);
                chk8("c5_imm", imm, 8'h0B);
            end
            if (c == 7) begin
                chk8("c7_rd", 8'(rd_sel), 8'h02);
                chk8("c7_rs", 8'(rs_sel), 8'h01);
                chk8("c7_alu", 8'(alu_op), 8'h02);
                chk1("c7_flags", flags_we, 1'b1);
                chk1("c7_wb", wb_sel, 1'b0);
            end
            tick();
        end

        // JMP 10 at 00, then JMP 40 at 10.
        clear_mem();
        mem[8'h00] = 8'hC0; mem[8'h01] = 8'h10;
        mem[8'h10] = 8'hC0; mem[8'h11] = 8'h40;
        mem[8'h40] = 8'hF0;
        do_reset();
        tick(); tick(); tick();
        chk8("jmp1_addr", imem_addr, 8'h10);
        tick(); tick();
        chk1("jmp_exec_we", reg_we, 1'b0);
        chk8("jmp_exec_rd", 8'(rd_sel), 8'h00);
        tick();
        chk8("jmp2_addr", imem_addr, 8'h40);

        // JZ 80 not taken, then JZ 80 taken.
        clear_mem();
        mem[0] = 8'hD0; mem[1] = 8'h80; mem[2] = 8'hD0; mem[3] = 8'h80;
        zero_flag = 1'b0;
        do_reset();
        tick(); tick(); tick();
        chk8("jz_nt_addr", imem_addr, 8'h02);
        zero_flag = 1'b1;
        tick(); tick(); tick();
        chk8("jz_t_addr", imem_addr, 8'h80);
        zero_flag = 1'b0;

        // Stall for three cycles in LOAD r3,33 EXECUTE.
        clear_mem();
        mem[0] = 8'h9C; mem[1] = 8'h33; mem[2] = 8'hF0;
        do_reset();
        tick(); tick();
        pulses = 0;
        stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk1("stall_we", reg_we, 1'b0);
            chk8("stall_pc", imem_addr, 8'h02);
            if (reg_we) pulses++;
            tick();
        end
        stall = 1'b0;
        #1;
        chk1("unstall_we", reg_we, 1'b1);
        chk1("unstall_wb", wb_sel, 1'b1);
        chk8("unstall_rd", 8'(rd_sel), 8'h03);
        chk8("unstall_imm", imm, 8'h33);
        if (reg_we) pulses++;
        tick();
        if (reg_we) pulses++;
        chk8("post_stall_addr", imem_addr, 8'h02);
        chk8("stall_pulses", 8'(pulses), 8'h01);

        // LOAD at FF wraps its operand to 00.
        clear_mem();
        mem[0] = 8'hC0; mem[1] = 8'hFF;
        do_reset();
        tick();
        mem[8'h00] = 8'h55; mem[8'hFF] = 8'h90;
        tick(); tick();
        chk8("wrap_fetch_addr", imem_addr, 8'hFF);
        tick();
        chk8("wrap_opnd_addr", imem_addr, 8'h00);
        tick();
        chk8("wrap_imm", imm, 8'h55);
        chk1("wrap_we", reg_we, 1'b1);
        tick();
        chk8("wrap_next_addr", imem_addr, 8'h01);

        // Reset asserted during OPERAND aborts LOAD; then normal resume.
        clear_mem();
        mem[0] = 8'h9C; mem[1] = 8'h33; mem[2] = 8'hF0;
        do_reset();
        tick();
        chk8("opnd_addr", imem_addr, 8'h01);
        rst_n = 1'b0;
        #1;
        chk8("midrst_addr", imem_addr, 8'h00);
        chk1("midrst_we", reg_we, 1'b0);
        tick();
        chk1("midrst_we2", reg_we, 1'b0);
        chk8("midrst_addr2", imem_addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk8("resume_addr", imem_addr, 8'h00);
        chk1("resume_c0_we", reg_we, 1'b0);
        tick(); tick();
        chk1("resume_we", reg_we, 1'b1);
        chk8("resume_imm", imm, 8'h33);

        // Illegal opcode, MOV, HLT, then reset out of HALT.
        clear_mem();
        mem[0] = 8'h70; mem[1] = 8'h6B; mem[2] = 8'hF0;
        do_reset();
        tick();
        chk1("ill_pulse", illegal_op, 1'b1);
        chk1("ill_we", reg_we, 1'b0);
        tick();
        chk1("ill_gone", illegal_op, 1'b0);
        tick();
        chk1("mov_we", reg_we, 1'b1);
        chk8("mov_alu", 8'(alu_op), 8'h06);
        chk1("mov_flags", flags_we, 1'b0);
        chk8("mov_rd", 8'(rd_sel), 8'h02);
        chk8("mov_rs", 8'(rs_sel), 8'h03);
        tick(); tick();
        chk1("hlt_not_yet", halted, 1'b0);
        tick();
        chk1("hlt_halted", halted, 1'b1);
        chk8("hlt_addr", imem_addr, 8'h03);
        tick();
        chk8("hlt_addr_hold", imem_addr, 8'h03);
        rst_n = 1'b0;
        #1;
        chk1("hrst_halted", halted, 1'b0);
        chk8("hrst_addr", imem_addr, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick();
        chk1("hrst_resume_ill", illegal_op, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
